// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CORE = 2'd1,
        S_EXT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_EXT  = 1'b1
    } owner_t;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 64;
    localparam int DEF_MAX_WAIT = 8;
    localparam int WAIT_CNT_W   = 8;
    localparam int STAT_W       = 32;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive cycles the external master was denied the port.
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  clr,
    output logic [WAIT_CNT_W-1:0] count,
    output logic                  max_reached
);

    localparam logic [WAIT_CNT_W-1:0] MAX_V = WAIT_CNT_W'(MAX_WAIT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + 1'b1;
        end
    end

    assign max_reached = (count == MAX_V);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single data-SRAM port (core MEM stage vs. external master).
// Optional per-cycle conflict/stall counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_wen,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              ext_req,
    input  logic              ext_wen,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_lock,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_conflicts,
    output logic [STAT_W-1:0] stat_stalls
`endif
);

    state_t              state;
    state_t              next_state;
    logic                max_reached;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rd_pend;
    owner_t              rd_owner;
    logic [DATA_W-1:0]   core_rdata_q;
    logic [DATA_W-1:0]   ext_rdata_q;

    dmem_arb_starve_cnt #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .inc        (ext_req && !ext_gnt),
        .clr        (ext_gnt || !ext_req),
        .count      (),
        .max_reached(max_reached)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_pend      <= 1'b0;
            rd_owner     <= OWN_CORE;
            core_rdata_q <= '0;
            ext_rdata_q  <= '0;
        end else begin
            state    <= next_state;
            addr_q   <= mem_addr;
            wdata_q  <= mem_wdata;
            rd_pend  <= mem_ren;
            rd_owner <= ext_gnt ? OWN_EXT : OWN_CORE;
            if (core_rvalid) begin
                core_rdata_q <= mem_rdata;
            end
            if (ext_rvalid) begin
                ext_rdata_q <= mem_rdata;
            end
        end
    end

    // A locked burst keeps the port; otherwise the core wins unless ext has starved.
    always_comb begin
        next_state = S_IDLE;
        ext_gnt    = 1'b0;
        core_gnt   = 1'b0;
        if (!rst) begin
            ext_gnt  = ext_req && (((state == S_EXT) && ext_lock) || !core_req || max_reached);
            core_gnt = core_req && !ext_gnt;
        end
        if (ext_gnt) begin
            next_state = ext_lock ? S_EXT : S_IDLE;
        end else if (core_gnt) begin
            next_state = S_CORE;
        end
        core_stall = !rst && core_req && !core_gnt;

        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (ext_gnt) begin
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end else if (core_gnt) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
        mem_wen = (core_gnt && core_wen) || (ext_gnt && ext_wen);
        mem_ren = (core_gnt && !core_wen) || (ext_gnt && !ext_wen);

        core_rvalid = !rst && rd_pend && (rd_owner == OWN_CORE);
        ext_rvalid  = !rst && rd_pend && (rd_owner == OWN_EXT);
        core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
        ext_rdata   = ext_rvalid ? mem_rdata : ext_rdata_q;
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_conflicts <= '0;
            stat_stalls    <= '0;
        end else begin
            if (core_req && ext_req) begin
                stat_conflicts <= stat_conflicts + 1'b1;
            end
            if (core_stall) begin
                stat_stalls <= stat_stalls + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a behavioural 1-cycle SRAM.
// Build with DMEM_ARB_STATS_EN defined to also check the statistics counters.
module tb_dmem_port_arbiter;

    typedef struct {
        logic [63:0] data;
        int          due;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0, core_wen = 1'b0, ext_req = 1'b0, ext_wen = 1'b0, ext_lock = 1'b0;
    logic [9:0]  core_addr = '0, ext_addr = '0;
    logic [63:0] core_wdata = '0, ext_wdata = '0;
    logic        core_gnt, core_rvalid, core_stall, ext_gnt, ext_rvalid;
    logic [63:0] core_rdata, ext_rdata;
    logic [9:0]  mem_addr;
    logic        mem_wen, mem_ren;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_conflicts, stat_stalls;
`endif

    logic [63:0] sram    [0:1023];
    logic [63:0] ref_mem [0:1023];
    rd_exp_t     core_q[$];
    rd_exp_t     ext_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [9:0]  last_addr = '0;
    logic [63:0] last_wdata = '0;

    dmem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_wen   (core_wen),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rvalid(core_rvalid),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .ext_req    (ext_req),
        .ext_wen    (ext_wen),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_lock   (ext_lock),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_conflicts(stat_conflicts),
        .stat_stalls   (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] initVal(input int a);
        if (a == 5) return 64'hA;
        if (a == 6) return 64'hB;
        return 64'h1000_0000_0000_0000 | 64'(a);
    endfunction

    // Behavioural SRAM: reloaded with known contents whenever rst is high.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            for (int i = 0; i < 1024; i++) sram[i] <= initVal(i);
            mem_rdata <= '0;
        end else begin
            if (mem_wen) sram[mem_addr] <= mem_wdata;
            if (mem_ren) mem_rdata <= sram[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Read-return monitor: an rvalid is required exactly when the oldest expectation falls due.
    always @(negedge clk) begin
        logic exp_c, exp_e;
        exp_c = (core_q.size() > 0) && (core_q[0].due == cyc);
        exp_e = (ext_q.size() > 0) && (ext_q[0].due == cyc);
        checkOutput("core_rvalid", {63'b0, core_rvalid}, {63'b0, exp_c});
        checkOutput("ext_rvalid", {63'b0, ext_rvalid}, {63'b0, exp_e});
        if (exp_c) begin
            checkOutput("core_rdata", core_rdata, core_q[0].data);
            void'(core_q.pop_front());
        end
        if (exp_e) begin
            checkOutput("ext_rdata", ext_rdata, ext_q[0].data);
            void'(ext_q.pop_front());
        end
    end

    task automatic applyStimulus(
        input logic c_req, input logic c_wen, input logic [9:0] c_addr, input logic [63:0] c_wdata,
        input logic e_req, input logic e_wen, input logic [9:0] e_addr, input logic [63:0] e_wdata,
        input logic e_lock, input logic exp_cg, input logic exp_eg);
        rd_exp_t e;
        core_req = c_req; core_wen = c_wen; core_addr = c_addr; core_wdata = c_wdata;
        ext_req = e_req; ext_wen = e_wen; ext_addr = e_addr; ext_wdata = e_wdata; ext_lock = e_lock;
        @(negedge clk);
        checkOutput("core_gnt", {63'b0, core_gnt}, {63'b0, exp_cg});
        checkOutput("ext_gnt", {63'b0, ext_gnt}, {63'b0, exp_eg});
        checkOutput("core_stall", {63'b0, core_stall}, {63'b0, c_req & ~exp_cg});
        checkOutput("mem_wen", {63'b0, mem_wen}, {63'b0, (exp_cg & c_wen) | (exp_eg & e_wen)});
        checkOutput("mem_ren", {63'b0, mem_ren}, {63'b0, (exp_cg & ~c_wen) | (exp_eg & ~e_wen)});
        if (exp_eg) begin
            last_addr = e_addr; last_wdata = e_wdata;
        end else if (exp_cg) begin
            last_addr = c_addr; last_wdata = c_wdata;
        end
        checkOutput("mem_addr", {54'b0, mem_addr}, {54'b0, last_addr});
        checkOutput("mem_wdata", mem_wdata, last_wdata);
        e.due = cyc + 1;
        if (exp_eg) begin
            if (e_wen) ref_mem[e_addr] = e_wdata;
            else begin e.data = ref_mem[e_addr]; ext_q.push_back(e); end
        end else if (exp_cg) begin
            if (c_wen) ref_mem[c_addr] = c_wdata;
            else begin e.data = ref_mem[c_addr]; core_q.push_back(e); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0);
    endtask

    task automatic resetRefs();
        for (int i = 0; i < 1024; i++) ref_mem[i] = initVal(i);
        last_addr = '0;
        last_wdata = '0;
    endtask

    initial begin
        resetRefs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_core_gnt", {63'b0, core_gnt}, 64'd0);
        checkOutput("rst_ext_gnt", {63'b0, ext_gnt}, 64'd0);
        checkOutput("rst_mem_wen", {63'b0, mem_wen}, 64'd0);
        checkOutput("rst_mem_ren", {63'b0, mem_ren}, 64'd0);
        checkOutput("rst_mem_addr", {54'b0, mem_addr}, 64'd0);
        checkOutput("rst_core_rdata", core_rdata, 64'd0);
        checkOutput("rst_state", {62'b0, dut.state}, 64'd0);
        checkOutput("rst_wait_cnt", {56'b0, dut.u_starve.count}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Core-only back-to-back reads.
        applyStimulus(1, 0, 10'd5, '0, 0, 0, '0, '0, 0, 1, 0);
        applyStimulus(1, 0, 10'd6, '0, 0, 0, '0, '0, 0, 1, 0);
        idle(2);
        checkOutput("core_rdata_hold", core_rdata, 64'hB);
        checkOutput("ext_rdata_hold", ext_rdata, 64'd0);

        // Simultaneous single requests.
        applyStimulus(1, 0, 10'd10, '0, 1, 0, 10'd11, '0, 0, 1, 0);
        checkOutput("wait_cnt_1", {56'b0, dut.u_starve.count}, 64'd1);
        applyStimulus(0, 0, '0, '0, 1, 0, 10'd11, '0, 0, 0, 1);
        checkOutput("wait_cnt_clr", {56'b0, dut.u_starve.count}, 64'd0);
        idle(2);

        // Starvation: ext forced ahead on the 9th contested cycle.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 0, 10'(20 + i), '0, 1, 1, 10'd30, 64'hDEAD_BEEF, 0, i < 8, i == 8);
            if (i == 7) checkOutput("wait_cnt_max", {56'b0, dut.u_starve.count}, 64'd8);
        end
        idle(2);

        // Locked ext burst after starvation, core requesting throughout.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 0, 10'd50, '0, 1, 1, (i < 8) ? 10'd0 : 10'(i - 8),
                          64'hB0 + 64'((i < 8) ? 0 : i - 8), 1, i < 8, i >= 8);
            if (i == 8) checkOutput("state_ext", {62'b0, dut.state}, 64'd2);
        end
        applyStimulus(1, 0, 10'd50, '0, 0, 0, '0, '0, 0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 10'(i), '0, 0, 0, '0, '0, 0, 1, 0);
        idle(2);

        // Reset right after a locked ext read is granted.
        applyStimulus(0, 0, '0, '0, 1, 0, 10'd2, '0, 1, 0, 1);
        core_req = 1; ext_req = 1; ext_lock = 1; ext_wen = 0;
        rst = 1'b1;
        ext_q.delete();
        core_q.delete();
        @(negedge clk);
        checkOutput("mid_rst_core_gnt", {63'b0, core_gnt}, 64'd0);
        checkOutput("mid_rst_ext_gnt", {63'b0, ext_gnt}, 64'd0);
        checkOutput("mid_rst_stall", {63'b0, core_stall}, 64'd0);
        checkOutput("mid_rst_mem_ren", {63'b0, mem_ren}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetRefs();
        checkOutput("post_rst_state", {62'b0, dut.state}, 64'd0);
        checkOutput("post_rst_wait_cnt", {56'b0, dut.u_starve.count}, 64'd0);
        checkOutput("post_rst_ext_rdata", ext_rdata, 64'd0);
        idle(1);

        // Three conflict cycles inside a locked burst: all stall the core.
        applyStimulus(0, 0, '0, '0, 1, 1, 10'd7, 64'h7, 1, 0, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, 10'd8, '0, 1, 1, 10'(8 + i), 64'(8 + i), 1, 0, 1);
        idle(1);
        for (int i = 7; i < 11; i++) applyStimulus(1, 0, 10'(i), '0, 0, 0, '0, '0, 0, 1, 0);
        idle(2);
`ifdef DMEM_ARB_STATS_EN
        checkOutput("stat_conflicts", {32'b0, stat_conflicts}, 64'd3);
        checkOutput("stat_stalls", {32'b0, stat_stalls}, 64'd3);
`endif

        checkOutput("core_q_empty", 64'(core_q.size()), 64'd0);
        checkOutput("ext_q_empty", 64'(ext_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
